// File: rtl/execution_pipe.sv
// RISC-V execute stage: combinational ALU, branch/jump resolution and a valid/ready output register.
// Define EXEC_MDU_EN to add the iterative multiply/divide unit and its FSM.
`ifndef EXEC_OP_DEFS
`define EXEC_OP_DEFS
`define ADD    6'd0
`define SUB    6'd1
`define SLL    6'd2
`define SLT    6'd3
`define SLTU   6'd4
`define XOR    6'd5
`define SRL    6'd6
`define SRA    6'd7
`define OR     6'd8
`define AND    6'd9
`define LUI    6'd10
`define JAL    6'd16
`define JALR   6'd17
`define MUL    6'd24
`define MULH   6'd25
`define MULHSU 6'd26
`define MULHU  6'd27
`define DIV    6'd28
`define DIVU   6'd29
`define REM    6'd30
`define REMU   6'd31
`endif

module execution_pipe #(
    parameter int XLEN   = 32,
    parameter int CTRL_W = 6
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              flush,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [CTRL_W-1:0] ALU_Control,
    input  logic              branch_op,
    input  logic [2:0]        branch_funct3,
    input  logic [XLEN-1:0]   operand_A,
    input  logic [XLEN-1:0]   operand_B,
    input  logic [XLEN-1:0]   Rdata1,
    input  logic [XLEN-1:0]   Rdata2,
    input  logic [XLEN-1:0]   imm32,
    input  logic [XLEN-1:0]   PC,
    input  logic [4:0]        Rd,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [XLEN-1:0]   ALU_result,
    output logic [XLEN-1:0]   Rdata2_out,
    output logic [4:0]        Rd_out,
    output logic              jump_flag,
    output logic [XLEN-1:0]   jump_target_PC,
    output logic              busy
);
    localparam int SH_W = $clog2(XLEN);
    localparam logic [XLEN-1:0] LINK_OFS = XLEN'(4);
    localparam logic [1:0] S_IDLE = 2'd0;

    logic [1:0]      state;
    logic            out_free, accept, alu_load, is_mdu;
    logic [XLEN-1:0] alu_res, jump_tgt, br_sum, jalr_sum;
    logic            jump_tk;
    logic            mdu_load;
    logic [XLEN-1:0] mdu_val, mdu_rdata2;
    logic [4:0]      mdu_rd;

    assign out_free = !out_valid || out_ready;
    assign in_ready = !flush && (state == S_IDLE) && out_free;
    assign accept   = in_valid && in_ready;
    assign alu_load = accept && !is_mdu;
    assign busy     = state != S_IDLE;

    // JAL/JALR produce the link address; codes not listed (including MDU codes) yield 0
    always_comb begin
        alu_res = '0;
        case (ALU_Control)
            `ADD:        alu_res = operand_A + operand_B;
            `SUB:        alu_res = operand_A - operand_B;
            `SLL:        alu_res = operand_A << operand_B[SH_W-1:0];
            `SLT:        alu_res = {{(XLEN-1){1'b0}}, $signed(operand_A) < $signed(operand_B)};
            `SLTU:       alu_res = {{(XLEN-1){1'b0}}, operand_A < operand_B};
            `XOR:        alu_res = operand_A ^ operand_B;
            `SRL:        alu_res = operand_A >> operand_B[SH_W-1:0];
            `SRA:        alu_res = $unsigned($signed(operand_A) >>> operand_B[SH_W-1:0]);
            `OR:         alu_res = operand_A | operand_B;
            `AND:        alu_res = operand_A & operand_B;
            `LUI:        alu_res = operand_B;
            `JAL, `JALR: alu_res = PC + LINK_OFS;
            default:     alu_res = '0;
        endcase
    end

    assign br_sum   = PC + imm32;
    assign jalr_sum = Rdata1 + imm32;

    always_comb begin
        jump_tk  = 1'b0;
        jump_tgt = '0;
        if (ALU_Control == `JAL) begin
            jump_tk  = 1'b1;
            jump_tgt = br_sum;
        end else if (ALU_Control == `JALR) begin
            jump_tk  = 1'b1;
            jump_tgt = {jalr_sum[XLEN-1:1], 1'b0};
        end else if (branch_op) begin
            jump_tgt = br_sum;
            case (branch_funct3)
                3'b000:  jump_tk = Rdata1 == Rdata2;
                3'b001:  jump_tk = Rdata1 != Rdata2;
                3'b100:  jump_tk = $signed(Rdata1) < $signed(Rdata2);
                3'b101:  jump_tk = $signed(Rdata1) >= $signed(Rdata2);
                3'b110:  jump_tk = Rdata1 < Rdata2;
                3'b111:  jump_tk = Rdata1 >= Rdata2;
                default: jump_tk = 1'b0;
            endcase
        end
    end

`ifdef EXEC_MDU_EN
    localparam logic [1:0] S_MUL = 2'd1, S_DIV = 2'd2, S_DONE = 2'd3;

    logic              is_mul, is_div, rem_op, div_sgn, div_zero, div_ovf, a_neg, b_neg;
    logic [XLEN-1:0]   a_mag, b_mag;
    logic              mul_hi, mul_a_sgn, mul_b_sgn, want_rem, q_neg, r_neg;
    logic [XLEN-1:0]   mul_a, mul_b, dq, dr, db, mdu_res, rd2_l;
    logic [4:0]        rd_l;
    logic [SH_W-1:0]   cnt;
    logic [2*XLEN-1:0] mul_ax, mul_bx, prod;
    logic [XLEN-1:0]   mul_res, nxt_q, nxt_r, q_fix, r_fix;
    logic [XLEN:0]     shifted, diff;

    assign is_mul   = ALU_Control inside {`MUL, `MULH, `MULHSU, `MULHU};
    assign is_div   = ALU_Control inside {`DIV, `DIVU, `REM, `REMU};
    assign is_mdu   = is_mul || is_div;
    assign rem_op   = (ALU_Control == `REM) || (ALU_Control == `REMU);
    assign div_sgn  = (ALU_Control == `DIV) || (ALU_Control == `REM);
    assign a_neg    = div_sgn && operand_A[XLEN-1];
    assign b_neg    = div_sgn && operand_B[XLEN-1];
    assign a_mag    = a_neg ? -operand_A : operand_A;
    assign b_mag    = b_neg ? -operand_B : operand_B;
    assign div_zero = operand_B == '0;
    assign div_ovf  = div_sgn && (operand_A == {1'b1, {(XLEN-1){1'b0}}}) && (operand_B == '1);

    // extending to 2*XLEN makes the modular product equal the exact signed/unsigned one
    assign mul_ax  = {{XLEN{mul_a_sgn && mul_a[XLEN-1]}}, mul_a};
    assign mul_bx  = {{XLEN{mul_b_sgn && mul_b[XLEN-1]}}, mul_b};
    assign prod    = mul_ax * mul_bx;
    assign mul_res = mul_hi ? prod[2*XLEN-1:XLEN] : prod[XLEN-1:0];

    // one restoring step: dividend bits shift out of dq into dr, quotient bits shift into dq
    assign shifted = {dr, dq[XLEN-1]};
    assign diff    = shifted - {1'b0, db};
    assign nxt_r   = diff[XLEN] ? shifted[XLEN-1:0] : diff[XLEN-1:0];
    assign nxt_q   = {dq[XLEN-2:0], !diff[XLEN]};
    assign q_fix   = q_neg ? -nxt_q : nxt_q;
    assign r_fix   = r_neg ? -nxt_r : nxt_r;

    // a finished multiply goes straight to the output register when it is free
    assign mdu_load   = ((state == S_MUL) || (state == S_DONE)) && out_free;
    assign mdu_val    = (state == S_MUL) ? mul_res : mdu_res;
    assign mdu_rdata2 = rd2_l;
    assign mdu_rd     = rd_l;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= S_IDLE;
            mul_a     <= '0;
            mul_b     <= '0;
            mul_hi    <= 1'b0;
            mul_a_sgn <= 1'b0;
            mul_b_sgn <= 1'b0;
            want_rem  <= 1'b0;
            q_neg     <= 1'b0;
            r_neg     <= 1'b0;
            dq        <= '0;
            dr        <= '0;
            db        <= '0;
            cnt       <= '0;
            mdu_res   <= '0;
            rd2_l     <= '0;
            rd_l      <= '0;
        end else if (flush) begin
            state <= S_IDLE;
        end else begin
            case (state)
                S_IDLE: if (accept && is_mdu) begin
                    rd_l     <= Rd;
                    rd2_l    <= Rdata2;
                    want_rem <= rem_op;
                    if (is_mul) begin
                        state     <= S_MUL;
                        mul_a     <= operand_A;
                        mul_b     <= operand_B;
                        mul_hi    <= ALU_Control != `MUL;
                        mul_a_sgn <= (ALU_Control == `MULH) || (ALU_Control == `MULHSU);
                        mul_b_sgn <= ALU_Control == `MULH;
                    end else if (div_zero) begin
                        state   <= S_DONE;
                        mdu_res <= rem_op ? operand_A : '1;
                    end else if (div_ovf) begin
                        state   <= S_DONE;
                        mdu_res <= rem_op ? '0 : operand_A;
                    end else begin
                        state <= S_DIV;
                        dq    <= a_mag;
                        dr    <= '0;
                        db    <= b_mag;
                        cnt   <= '0;
                        q_neg <= a_neg ^ b_neg;
                        r_neg <= a_neg;
                    end
                end
                S_MUL: begin
                    state   <= out_free ? S_IDLE : S_DONE;
                    mdu_res <= mul_res;
                end
                S_DIV: begin
                    dq  <= nxt_q;
                    dr  <= nxt_r;
                    cnt <= cnt + 1'b1;
                    if (cnt == SH_W'(XLEN - 1)) begin
                        state   <= S_DONE;
                        mdu_res <= want_rem ? r_fix : q_fix;
                    end
                end
                default: if (out_free) state <= S_IDLE;
            endcase
        end
    end
`else
    assign state      = S_IDLE;
    assign is_mdu     = 1'b0;
    assign mdu_load   = 1'b0;
    assign mdu_val    = '0;
    assign mdu_rdata2 = '0;
    assign mdu_rd     = '0;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid      <= 1'b0;
            ALU_result     <= '0;
            Rdata2_out     <= '0;
            Rd_out         <= '0;
            jump_flag      <= 1'b0;
            jump_target_PC <= '0;
        end else if (flush) begin
            out_valid <= 1'b0;
        end else if (alu_load) begin
            out_valid      <= 1'b1;
            ALU_result     <= alu_res;
            Rdata2_out     <= Rdata2;
            Rd_out         <= Rd;
            jump_flag      <= jump_tk;
            jump_target_PC <= jump_tgt;
        end else if (mdu_load) begin
            out_valid      <= 1'b1;
            ALU_result     <= mdu_val;
            Rdata2_out     <= mdu_rdata2;
            Rd_out         <= mdu_rd;
            jump_flag      <= 1'b0;
            jump_target_PC <= '0;
        end else if (out_ready) begin
            out_valid <= 1'b0;
        end
    end
endmodule

// File: tb/tb_execution_pipe.sv
// Scoreboard bench for execution_pipe: randomized ops against an arithmetic reference model.
module tb_execution_pipe;
    localparam logic [5:0] OP_ADD = 6'd0, OP_SUB = 6'd1, OP_SLL = 6'd2, OP_SLT = 6'd3,
        OP_SLTU = 6'd4, OP_XOR = 6'd5, OP_SRL = 6'd6, OP_SRA = 6'd7, OP_OR = 6'd8,
        OP_AND = 6'd9, OP_LUI = 6'd10, OP_JAL = 6'd16, OP_JALR = 6'd17,
        OP_MUL = 6'd24, OP_MULH = 6'd25, OP_MULHSU = 6'd26, OP_MULHU = 6'd27,
        OP_DIV = 6'd28, OP_DIVU = 6'd29, OP_REM = 6'd30, OP_REMU = 6'd31;

    logic clk = 1'b0, rst_n = 1'b0, flush = 1'b0, in_valid = 1'b0, out_ready = 1'b1;
    logic in_ready, out_valid, jump_flag, busy;
    logic branch_op = 1'b0;
    logic [5:0] ALU_Control = '0;
    logic [2:0] branch_funct3 = '0;
    logic [31:0] operand_A = '0, operand_B = '0, Rdata1 = '0, Rdata2 = '0, imm32 = '0, PC = '0;
    logic [4:0] Rd = '0, Rd_out;
    logic [31:0] ALU_result, Rdata2_out, jump_target_PC;

    typedef struct packed {
        logic [31:0] res;
        logic [31:0] rd2;
        logic [4:0]  rd;
        logic        jf;
        logic [31:0] jt;
    } exp_t;

    exp_t sbq[$];
    int checks = 0, errors = 0;
    bit rand_ready = 1'b0, ready_force = 1'b1;

    execution_pipe #(.XLEN(32), .CTRL_W(6)) dut (
        .clk(clk), .rst_n(rst_n), .flush(flush), .in_valid(in_valid), .in_ready(in_ready),
        .ALU_Control(ALU_Control), .branch_op(branch_op), .branch_funct3(branch_funct3),
        .operand_A(operand_A), .operand_B(operand_B), .Rdata1(Rdata1), .Rdata2(Rdata2),
        .imm32(imm32), .PC(PC), .Rd(Rd), .out_valid(out_valid), .out_ready(out_ready),
        .ALU_result(ALU_result), .Rdata2_out(Rdata2_out), .Rd_out(Rd_out),
        .jump_flag(jump_flag), .jump_target_PC(jump_target_PC), .busy(busy)
    );

    always #5 clk = ~clk;

    task automatic check(string name, logic [31:0] act, logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic bit is_mdu_op(logic [5:0] op);
        return op inside {OP_MUL, OP_MULH, OP_MULHSU, OP_MULHU, OP_DIV, OP_DIVU, OP_REM, OP_REMU};
    endfunction

    function automatic exp_t model(logic [5:0] op, logic bop, logic [2:0] f3,
                                   logic [31:0] a, logic [31:0] b, logic [31:0] r1,
                                   logic [31:0] r2, logic [31:0] imm, logic [31:0] pc,
                                   logic [4:0] rd);
        exp_t e;
        longint sa, sb, ua, ub;
        logic [63:0] p;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        ua = {32'h0, a};
        ub = {32'h0, b};
        e.rd2 = r2;
        e.rd  = rd;
        e.res = '0;
        case (op)
            OP_ADD:  e.res = a + b;
            OP_SUB:  e.res = a - b;
            OP_SLL:  e.res = a << b[4:0];
            OP_SLT:  e.res = (sa < sb) ? 32'd1 : 32'd0;
            OP_SLTU: e.res = (ua < ub) ? 32'd1 : 32'd0;
            OP_XOR:  e.res = a ^ b;
            OP_SRL:  e.res = a >> b[4:0];
            OP_SRA:  e.res = 32'(sa >>> b[4:0]);
            OP_OR:   e.res = a | b;
            OP_AND:  e.res = a & b;
            OP_LUI:  e.res = b;
            OP_JAL, OP_JALR: e.res = pc + 32'd4;
`ifdef EXEC_MDU_EN
            OP_MUL:    begin p = sa * sb; e.res = p[31:0]; end
            OP_MULH:   begin p = sa * sb; e.res = p[63:32]; end
            OP_MULHSU: begin p = sa * ub; e.res = p[63:32]; end
            OP_MULHU:  begin p = ua * ub; e.res = p[63:32]; end
            OP_DIV:  e.res = (b == 0) ? 32'hFFFFFFFF :
                             (a == 32'h80000000 && b == 32'hFFFFFFFF) ? a : 32'(sa / sb);
            OP_REM:  e.res = (b == 0) ? a :
                             (a == 32'h80000000 && b == 32'hFFFFFFFF) ? 32'd0 : 32'(sa % sb);
            OP_DIVU: e.res = (b == 0) ? 32'hFFFFFFFF : a / b;
            OP_REMU: e.res = (b == 0) ? a : a % b;
`endif
            default: e.res = '0;
        endcase
        e.jf = 1'b0;
        e.jt = '0;
        if (op == OP_JAL) begin
            e.jf = 1'b1; e.jt = pc + imm;
        end else if (op == OP_JALR) begin
            e.jf = 1'b1; e.jt = (r1 + imm) & 32'hFFFFFFFE;
        end else if (bop && !is_mdu_op(op)) begin
            e.jt = pc + imm;
            case (f3)
                3'b000: e.jf = r1 == r2;
                3'b001: e.jf = r1 != r2;
                3'b100: e.jf = $signed(r1) < $signed(r2);
                3'b101: e.jf = $signed(r1) >= $signed(r2);
                3'b110: e.jf = r1 < r2;
                3'b111: e.jf = r1 >= r2;
                default: e.jf = 1'b0;
            endcase
        end
        return e;
    endfunction

    function automatic int exp_lat(logic [5:0] op, logic [31:0] a, logic [31:0] b);
`ifdef EXEC_MDU_EN
        if (op inside {OP_MUL, OP_MULH, OP_MULHSU, OP_MULHU}) return 2;
        if (op inside {OP_DIVU, OP_REMU}) return (b == 0) ? 2 : 34;
        if (op inside {OP_DIV, OP_REM})
            return (b == 0 || (a == 32'h80000000 && b == 32'hFFFFFFFF)) ? 2 : 34;
`endif
        return 1;
    endfunction

    // out_ready changes at posedge+1; stimulus at posedge+2; monitor at negedge
    initial forever begin
        @(posedge clk);
        #1;
        out_ready = rand_ready ? 1'($urandom_range(0, 1)) : ready_force;
    end

    initial forever begin
        exp_t e;
        @(negedge clk);
        if (rst_n && !flush && out_valid && out_ready) begin
            if (sbq.size() == 0) begin
                checks++; errors++;
                $display("FAIL unexpected_output: got result %h expected no output", ALU_result);
            end else begin
                e = sbq.pop_front();
                check("result", ALU_result, e.res);
                check("rdata2_out", Rdata2_out, e.rd2);
                check("rd_out", {27'h0, Rd_out}, {27'h0, e.rd});
                check("jump_flag", {31'h0, jump_flag}, {31'h0, e.jf});
                check("jump_target", jump_target_PC, e.jt);
            end
        end
    end

    task automatic send(logic [5:0] op, logic bop, logic [2:0] f3, logic [31:0] a,
                        logic [31:0] b, logic [31:0] r1, logic [31:0] r2, logic [31:0] imm,
                        logic [31:0] pc, logic [4:0] rd, bit push);
        int n = 0;
        ALU_Control = op; branch_op = bop; branch_funct3 = f3;
        operand_A = a; operand_B = b; Rdata1 = r1; Rdata2 = r2; imm32 = imm; PC = pc; Rd = rd;
        in_valid = 1'b1;
        while (!in_ready && n < 200) begin
            @(posedge clk); #2; n++;
        end
        if (n >= 200) begin
            checks++; errors++;
            $display("FAIL accept_timeout: got in_ready 0 expected 1");
        end else if (push) begin
            sbq.push_back(model(op, bop, f3, a, b, r1, r2, imm, pc, rd));
        end
        @(posedge clk); #2;
        in_valid = 1'b0;
    endtask

    task automatic lat_test(string name, logic [5:0] op, logic bop, logic [2:0] f3,
                            logic [31:0] a, logic [31:0] b, logic [31:0] r1, logic [31:0] r2,
                            logic [31:0] imm, logic [31:0] pc);
        int lat = 1;
        send(op, bop, f3, a, b, r1, r2, imm, pc, 5'd3, 1'b1);
        while (!out_valid && lat < 100) begin
            @(posedge clk); #2; lat++;
        end
        check({name, "_latency"}, 32'(lat), 32'(exp_lat(op, a, b)));
    endtask

    task automatic drain();
        int n = 0;
        while ((sbq.size() != 0 || out_valid) && n < 2000) begin
            @(posedge clk); #2; n++;
        end
        check("drain", 32'(sbq.size()), 32'd0);
    endtask

    // kills an op mid-flight by flush or by reset; nothing may emerge afterwards
    task automatic abort_mid(bit use_flush);
        int seen = 0;
`ifdef EXEC_MDU_EN
        send(OP_DIV, 1'b0, 3'b0, 32'hFFFFFFF9, 32'd2, 0, 0, 0, 0, 5'd4, 1'b0);
        repeat (9) begin @(posedge clk); #2; end
        check("busy_during_div", {31'h0, busy}, 32'd1);
`else
        ready_force = 1'b0;
        @(posedge clk); #2;
        send(OP_ADD, 1'b0, 3'b0, 32'd9, 32'd9, 0, 0, 0, 0, 5'd4, 1'b0);
        check("held_valid", {31'h0, out_valid}, 32'd1);
`endif
        if (use_flush) begin
            flush = 1'b1;
            ALU_Control = OP_ADD; in_valid = 1'b1;
            check("in_ready_flush", {31'h0, in_ready}, 32'd0);
            @(posedge clk); #2;
            flush = 1'b0; in_valid = 1'b0;
        end else begin
            #1 rst_n = 1'b0;
            #1;
            check("rst_mid_ready", {31'h0, in_ready}, 32'd1);
            @(posedge clk); #2;
            rst_n = 1'b1;
        end
        check("abort_out_valid", {31'h0, out_valid}, 32'd0);
        check("abort_busy", {31'h0, busy}, 32'd0);
        ready_force = 1'b1;
        repeat (40) begin
            @(posedge clk); #2;
            if (out_valid) seen++;
        end
        check("abort_no_output", 32'(seen), 32'd0);
    endtask

    initial begin
        logic [5:0] alu_ops[13] = '{OP_ADD, OP_SUB, OP_SLL, OP_SLT, OP_SLTU, OP_XOR, OP_SRL,
                                    OP_SRA, OP_OR, OP_AND, OP_LUI, OP_JAL, OP_JALR};
        logic [5:0] mdu_ops[8] = '{OP_MUL, OP_MULH, OP_MULHSU, OP_MULHU,
                                   OP_DIV, OP_DIVU, OP_REM, OP_REMU};
        exp_t hold;
        #12;
        check("rst_out_valid", {31'h0, out_valid}, 32'd0);
        check("rst_result", ALU_result, 32'd0);
        check("rst_rdata2", Rdata2_out, 32'd0);
        check("rst_rd", {27'h0, Rd_out}, 32'd0);
        check("rst_jump_flag", {31'h0, jump_flag}, 32'd0);
        check("rst_jump_target", jump_target_PC, 32'd0);
        check("rst_busy", {31'h0, busy}, 32'd0);
        check("rst_in_ready", {31'h0, in_ready}, 32'd1);
        @(posedge clk); #2;
        rst_n = 1'b1;
        @(posedge clk); #2;

        lat_test("add", OP_ADD, 0, 3'b000, 32'd5, 32'd7, 0, 0, 0, 0);
        lat_test("blt", OP_ADD, 1, 3'b100, 0, 0, 32'hFFFFFFFF, 32'd1, 32'h20, 32'h100);
        lat_test("bltu", OP_ADD, 1, 3'b110, 0, 0, 32'hFFFFFFFF, 32'd1, 32'h20, 32'h100);
        lat_test("jalr", OP_JALR, 0, 3'b000, 0, 0, 32'h1001, 0, 32'd2, 32'h40);
        lat_test("div_ovf", OP_DIV, 0, 3'b000, 32'h80000000, 32'hFFFFFFFF, 0, 0, 0, 0);
        lat_test("rem_zero", OP_REM, 0, 3'b000, 32'd7, 32'd0, 0, 0, 0, 0);
        lat_test("div_neg", OP_DIV, 0, 3'b000, 32'hFFFFFFF9, 32'd2, 0, 0, 0, 0);
        lat_test("rem_neg", OP_REM, 0, 3'b000, 32'hFFFFFFF9, 32'd2, 0, 0, 0, 0);
        drain();

        ready_force = 1'b0;
        @(posedge clk); #2;
        hold = model(OP_MULHU, 0, 0, 32'hFFFFFFFF, 32'hFFFFFFFF, 0, 0, 0, 0, 5'd3);
        lat_test("mulhu", OP_MULHU, 0, 3'b000, 32'hFFFFFFFF, 32'hFFFFFFFF, 0, 0, 0, 0);
        repeat (5) begin
            check("stall_result", ALU_result, hold.res);
            check("stall_in_ready", {31'h0, in_ready}, 32'd0);
            @(posedge clk); #2;
        end
        ready_force = 1'b1;
        drain();

        abort_mid(1'b1);
        lat_test("add_after_flush", OP_ADD, 0, 3'b000, 32'd1, 32'd1, 0, 0, 0, 0);
        drain();
        abort_mid(1'b0);
        drain();

        for (int i = 0; i < 300; i++) begin
            logic [5:0] op;
            logic [31:0] a, b, r1, r2;
            logic bop;
            rand_ready = (i < 150);
            op = ($urandom_range(0, 9) < 7) ? alu_ops[$urandom_range(0, 12)]
                                            : mdu_ops[$urandom_range(0, 7)];
            a = $urandom(); b = $urandom(); r1 = $urandom(); r2 = $urandom();
            if ($urandom_range(0, 3) == 0) b = b & 32'h1F;
            if ($urandom_range(0, 7) == 0) b = 32'd0;
            if ($urandom_range(0, 9) == 0) begin a = 32'h80000000; b = 32'hFFFFFFFF; end
            if ($urandom_range(0, 3) == 0) r2 = r1;
            bop = (op != OP_JAL && op != OP_JALR && !is_mdu_op(op)) ? 1'($urandom_range(0, 1)) : 1'b0;
            send(op, bop, 3'($urandom_range(0, 7)), a, b, r1, r2, $urandom(), $urandom(),
                 5'($urandom_range(0, 31)), 1'b1);
            if ($urandom_range(0, 3) == 0) begin @(posedge clk); #2; end
        end
        rand_ready = 1'b0;
        ready_force = 1'b1;
        drain();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end
endmodule

// File: doc/execution_pipe.md
# execution_pipe

Registered, handshaked RISC-V execute stage with XLEN-parametrised datapath, full branch-condition resolution, and an optional iterative multiply/divide unit (MDU). Sits between the ID/EX and EX/MEM pipeline boundaries. Accepts one instruction per cycle for single-cycle ALU ops and stalls upstream through `in_ready` while a multi-cycle MDU op runs. Presents results to memaccess through a valid/ready output register.

## Interface
- `XLEN`, 32: datapath width. Must be at least 8.
- `CTRL_W`, 6: width of `ALU_Control`.
- `clk` input 1: sole clock, rising edge.
- `rst_n` input 1: asynchronous, active-low reset.
- `flush` input 1: synchronous kill of the in-flight op and the output register.
- `in_valid` input 1: ID/EX presents an instruction.
- `in_ready` output 1: stage accepts the instruction this cycle.
- `ALU_Control` input CTRL_W: op code, using the shared defines (`JAL`, `JALR`, `MUL`, `MULH`, `MULHSU`, `MULHU`, `DIV`, `DIVU`, `REM`, `REMU`).
- `branch_op` input 1: conditional branch.
- `branch_funct3` input 3: BEQ=000, BNE=001, BLT=100, BGE=101, BLTU=110, BGEU=111.
- `operand_A`, `operand_B` input XLEN: ALU operands.
- `Rdata1`, `Rdata2` input XLEN: register-file reads.
- `imm32` input XLEN: sign-extended immediate.
- `PC` input XLEN: instruction PC.
- `Rd` input 5: destination register.
- `out_valid` output 1: the output register holds a result.
- `out_ready` input 1: memaccess consumes the result.
- `ALU_result` output XLEN: registered result.
- `Rdata2_out` output XLEN: registered `Rdata2`.
- `Rd_out` output 5: registered `Rd`.
- `jump_flag` output 1: registered redirect. Meaningful only while `out_valid` is high.
- `jump_target_PC` output XLEN: registered redirect target.
- `busy` output 1: MDU FSM is not in IDLE.

## Operation
- Accept condition: `in_valid && in_ready`, where `in_ready = !flush && state==IDLE && (!out_valid || out_ready)`.
- Single-cycle ops go through the combinational `ALU`. The result is loaded into the output register at the accept edge.
- Redirect rules:
  - `JAL`: target = `PC+imm32`, flag=1.
  - `JALR`: target = `(Rdata1+imm32) & ~1`, flag=1.
  - Branch: target = `PC+imm32`, flag = comparison of `Rdata1` and `Rdata2` per `branch_funct3`. BLT/BGE compare signed; BLTU/BGEU compare unsigned.
  - Any other op: target=0, flag=0.
  - An unknown `branch_funct3` gives flag=0.
- All arithmetic is modulo 2^XLEN.
- MDU FSM states are IDLE, MUL, DIV, DONE.
  - IDLE to MUL: accepting a MUL-class op. Operands are latched.
  - MUL to DONE: after 1 cycle. The full 2·XLEN product is formed. MUL returns the low half. MULH, MULHSU and MULHU return the high half with signed×signed, signed×unsigned and unsigned×unsigned operands respectively.
  - IDLE to DIV: accepting a DIV-class op, with a nonzero divisor and no signed overflow.
  - DIV to DONE: after XLEN restoring-division iterations (1 bit/cycle) on magnitudes. Quotient and remainder signs are fixed afterwards. The remainder takes the sign of the dividend.
  - Divide by zero: go IDLE to DONE directly. Quotient = all ones, remainder = dividend.
  - Signed overflow (−2^(XLEN−1) / −1): go IDLE to DONE directly. Quotient = dividend, remainder = 0.
  - DONE to IDLE: when the output register is free (`!out_valid || out_ready`). The result is loaded with jump_flag=0. Otherwise the FSM waits in DONE.
- `flush`:
  - Clears `out_valid` and returns the FSM to IDLE at the next edge.
  - An instruction presented in a flush cycle is not accepted.
  - `flush` has priority over `out_ready` and over acceptance.
- Output register:
  - Holds its value while `out_valid && !out_ready`.
  - Clears `out_valid` on consume when no new result is loaded in the same cycle.
  - Consume and load in the same cycle is allowed (back-to-back throughput).

## Timing
- Reset values: `out_valid`=0, `ALU_result`=0, `Rdata2_out`=0, `Rd_out`=0, `jump_flag`=0, `jump_target_PC`=0, `busy`=0, FSM=IDLE. `in_ready` is 1 after reset when `flush`=0.
- Reset asserted mid-operation aborts the op immediately. No result is produced.
- Latency is measured from the accept edge to `out_valid` high, with `out_ready` held high:
  - Single-cycle ops: 1 cycle.
  - MUL class: 2 cycles.
  - DIV class: XLEN+2 cycles.
  - Divide by zero or overflow: 2 cycles.
- Throughput: 1 op per cycle for single-cycle ops. `in_ready` is low from the cycle after an MDU accept until the FSM is back in IDLE.
- `out_ready` low stretches DONE indefinitely. Result values are stable during the stretch.

## Configuration
- `EXEC_MDU_EN` defined: MDU and FSM are present as described.
- `EXEC_MDU_EN` undefined:
  - No MDU logic; FSM is tied to IDLE; `busy`=0.
  - MUL/DIV-class codes complete in 1 cycle with `ALU_result`=0 and `jump_flag`=0.

## Test plan
- ADD, operand_A=5, operand_B=7, out_ready=1 → next cycle out_valid=1, ALU_result=12, jump_flag=0.
- BLT, Rdata1=0xFFFFFFFF, Rdata2=1, PC=0x100, imm32=0x20 → jump_flag=1, target=0x120. BLTU with the same operands → jump_flag=0.
- JALR, Rdata1=0x1001, imm32=2 → jump_flag=1, target=0x1002.
- DIV 0x80000000 / 0xFFFFFFFF → 2 cycles, result 0x80000000. REM 7 / 0 → 2 cycles, result 7. DIV −7 / 2 → out_valid at cycle 34, result −3. REM −7 / 2 → result −1.
- MULHU 0xFFFFFFFF × 0xFFFFFFFF → result 0xFFFFFFFE at cycle 2. Hold out_ready=0 for 5 cycles → result stable, in_ready=0.
- Assert flush during DIV iteration 10 → out_valid stays 0, busy=0 next cycle. A following ADD 1+1 gives 2 after 1 cycle.
